// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display controller and the seven-segment path:
// FSM state encoding, the blank digit code and constant helper functions.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
    localparam logic [1:0] ST_COMMIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SHIFT  = ST_SHIFT_ENC,
        ST_COMMIT = ST_COMMIT_ENC
    } bcd_state_t;

    // Digit code the seven-segment decoder renders with all segments dark.
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] DIGIT_NINE = 4'h9;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // 10^n as a 64-bit constant.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display bus between a value producer and the BCD display controller.
interface bcd_display_ctrl_if #(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
);
    logic [BIN_WIDTH-1:0]      i_bin_data;
    logic                      i_valid;
    logic                      o_ready;
    logic [DISPLAYS_NUM*4-1:0] o_bcd_data;
    logic                      o_done;
    logic                      o_overflow;

    modport master (
        output i_bin_data, i_valid,
        input  o_ready, o_bcd_data, o_done, o_overflow
    );

    modport slave (
        input  i_bin_data, i_valid,
        output o_ready, o_bcd_data, o_done, o_overflow
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Add 3 to a digit that would carry past 9 after doubling.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter feeding the display multiplexer. A value is
// accepted over valid/ready, converted one bit per cycle, then committed to the
// display word in a single cycle so the multiplexer never sees a partial result.
module bcd_display_ctrl
    import bcd_pkg::*;
#(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14,
    parameter int BLANK_LZ     = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bcd_display_ctrl_if.slave  bus
);

    localparam int          DW      = DISPLAYS_NUM * 4;
    localparam int          CNT_W   = clogb2(BIN_WIDTH);
    localparam logic [63:0] MAX_VAL = pow10(DISPLAYS_NUM) - 64'd1;

    // Replace leading zero digits with BLANK_CODE; the units digit always shows.
    function automatic logic [DW-1:0] blank_digits(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          lead;
        r    = d;
        lead = 1'b1;
        for (int i = DISPLAYS_NUM - 1; i >= 1; i--) begin
            if (lead && (d[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    // Display form of a BCD word, with blanking applied when enabled.
    function automatic logic [DW-1:0] to_display(input logic [DW-1:0] d);
        if (BLANK_LZ != 0) begin
            return blank_digits(d);
        end else begin
            return d;
        end
    endfunction

    localparam logic [DW-1:0] RESET_DISP = to_display({DW{1'b0}});
    localparam logic [DW-1:0] SAT_DISP   = {DISPLAYS_NUM{DIGIT_NINE}};

    bcd_state_t           state_r, state_next_s;
    logic [BIN_WIDTH-1:0] bin_r, bin_next_s;
    logic [DW-1:0]        scratch_r, scratch_next_s, scratch_adj_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;
    logic                 ovf_r, ovf_next_s;
    logic [DW-1:0]        bcd_r, bcd_next_s;
    logic                 done_r, done_next_s;
    logic                 overflow_r, overflow_next_s;
    logic                 ready_r, ready_next_s;
    logic [63:0]          bin_ext_s;

    assign bin_ext_s = 64'(bus.i_bin_data);

    for (genvar g = 0; g < DISPLAYS_NUM; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (scratch_r[g*4 +: 4]),
            .o_digit (scratch_adj_s[g*4 +: 4])
        );
    end

    // Next-state and datapath decode for the IDLE -> SHIFT -> COMMIT sequence.
    always_comb begin
        state_next_s    = state_r;
        bin_next_s      = bin_r;
        scratch_next_s  = scratch_r;
        cnt_next_s      = cnt_r;
        ovf_next_s      = ovf_r;
        bcd_next_s      = bcd_r;
        overflow_next_s = overflow_r;
        done_next_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_valid && ready_r) begin
                    bin_next_s     = bus.i_bin_data;
                    scratch_next_s = {DW{1'b0}};
                    ovf_next_s     = (bin_ext_s > MAX_VAL);
                    cnt_next_s     = CNT_W'(BIN_WIDTH - 1);
                    state_next_s   = ST_SHIFT;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Digits shifted past the top of the scratch are dropped; overflow
                // comes from the range check made at accept time.
                scratch_next_s = {scratch_adj_s[DW-2:0], bin_r[BIN_WIDTH-1]};
                bin_next_s     = {bin_r[BIN_WIDTH-2:0], 1'b0};
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    cnt_next_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                if (ovf_r) begin
                    bcd_next_s = SAT_DISP;
                end else begin
                    bcd_next_s = to_display(scratch_r);
                end
                overflow_next_s = ovf_r;
                done_next_s     = 1'b1;
                state_next_s    = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        ready_next_s = (state_next_s == ST_IDLE);
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bin_r      <= {BIN_WIDTH{1'b0}};
            scratch_r  <= {DW{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            bcd_r      <= RESET_DISP;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            bin_r      <= bin_next_s;
            scratch_r  <= scratch_next_s;
            cnt_r      <= cnt_next_s;
            ovf_r      <= ovf_next_s;
            bcd_r      <= bcd_next_s;
            done_r     <= done_next_s;
            overflow_r <= overflow_next_s;
            ready_r    <= ready_next_s;
        end
    end

    assign bus.o_ready    = ready_r;
    assign bus.o_bcd_data = bcd_r;
    assign bus.o_done     = done_r;
    assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: one instance with leading-zero blanking
// and one without, driven with identical directed values.
module tb_bcd_display_ctrl;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1;
    exp_t e0;

    bcd_display_ctrl_if #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) if1 ();
    bcd_display_ctrl_if #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) if0 ();

    bcd_display_ctrl #(.DISPLAYS_NUM(4), .BIN_WIDTH(14), .BLANK_LZ(1)) u_dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (if1)
    );

    bcd_display_ctrl #(.DISPLAYS_NUM(4), .BIN_WIDTH(14), .BLANK_LZ(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor for the blanking instance.
    always @(negedge clk) begin
        if (if1.o_done) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL done1_unexpected: got bcd=%h ovf=%b, required no done", if1.o_bcd_data, if1.o_overflow);
            end else begin
                e1 = q1.pop_front();
                if (if1.o_bcd_data !== e1.bcd || if1.o_overflow !== e1.ovf) begin
                    errors++;
                    $display("FAIL commit1: got bcd=%h ovf=%b, required bcd=%h ovf=%b", if1.o_bcd_data, if1.o_overflow, e1.bcd, e1.ovf);
                end
            end
        end
    end

    // Monitor for the non-blanking instance.
    always @(negedge clk) begin
        if (if0.o_done) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL done0_unexpected: got bcd=%h ovf=%b, required no done", if0.o_bcd_data, if0.o_overflow);
            end else begin
                e0 = q0.pop_front();
                if (if0.o_bcd_data !== e0.bcd || if0.o_overflow !== e0.ovf) begin
                    errors++;
                    $display("FAIL commit0: got bcd=%h ovf=%b, required bcd=%h ovf=%b", if0.o_bcd_data, if0.o_overflow, e0.bcd, e0.ovf);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] x1, input logic [15:0] x0, input logic ov);
        exp_t t;
        t.bcd = x1;
        t.ovf = ov;
        q1.push_back(t);
        t.bcd = x0;
        q0.push_back(t);
    endtask

    // Wait for ready, present one value for a single edge; returns #1 after that edge.
    task automatic send(input logic [13:0] v, input logic [15:0] x1, input logic [15:0] x0,
                        input logic ov, input bit expect_commit);
        int n;
        n = 0;
        @(negedge clk);
        while (!if1.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=%b, required 1 within 100 cycles", if1.o_ready);
        end else begin
            if1.i_valid    = 1'b1;
            if1.i_bin_data = v;
            if0.i_valid    = 1'b1;
            if0.i_bin_data = v;
            if (expect_commit) begin
                push_exp(x1, x0, ov);
            end
            @(posedge clk);
            #1;
            if1.i_valid = 1'b0;
            if0.i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending=%0d, required 0", q1.size() + q0.size());
        end
    endtask

    initial begin
        int lat;
        int low;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if1.i_valid = 1'b0;
        if1.i_bin_data = 14'd0;
        if0.i_valid = 1'b0;
        if0.i_bin_data = 14'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_bcd1", 32'(if1.o_bcd_data), 32'h0000FFF0);
        chk("reset_bcd0", 32'(if0.o_bcd_data), 32'h00000000);
        chk("reset_ready", 32'(if1.o_ready), 32'd1);
        chk("reset_done", 32'(if1.o_done), 32'd0);
        chk("reset_ovf", 32'(if1.o_overflow), 32'd0);

        // 1234: latency and busy window.
        send(14'd1234, 16'h1234, 16'h1234, 1'b0, 1'b1);
        low = (if1.o_ready == 1'b0) ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!if1.o_ready) low++;
            if (if1.o_done) begin
                lat = k;
                break;
            end
        end
        chk("latency_1234", 32'(lat), 32'd15);
        chk("ready_low_1234", 32'(low), 32'd15);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(if1.o_done), 32'd0);

        // Blanking cases.
        send(14'd7, 16'hFFF7, 16'h0007, 1'b0, 1'b1);
        send(14'd0, 16'hFFF0, 16'h0000, 1'b0, 1'b1);

        // Saturation and boundary.
        send(14'd10000, 16'h9999, 16'h9999, 1'b1, 1'b1);
        send(14'd16383, 16'h9999, 16'h9999, 1'b1, 1'b1);
        send(14'd9999, 16'h9999, 16'h9999, 1'b0, 1'b1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("hold_bcd", 32'(if1.o_bcd_data), 32'h00009999);
        chk("hold_ovf", 32'(if1.o_overflow), 32'd0);

        // i_valid held high with changing data: only edge-0 and edge-16 values taken.
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if1.i_valid = 1'b1;
            if0.i_valid = 1'b1;
            if (k == 0) begin
                if1.i_bin_data = 14'd100;
                push_exp(16'hF100, 16'h0100, 1'b0);
            end else if (k == 16) begin
                if1.i_bin_data = 14'd4321;
                push_exp(16'h4321, 16'h4321, 1'b0);
            end else begin
                if1.i_bin_data = 14'(200 + k);
            end
            if0.i_bin_data = if1.i_bin_data;
            @(posedge clk);
            #1;
            if (k == 14) chk("busy_ready_e14", 32'(if1.o_ready), 32'd0);
            if (k == 15) chk("ready_e15", 32'(if1.o_ready), 32'd1);
            if (k == 16) chk("accept_e16", 32'(if1.o_ready), 32'd0);
        end
        @(negedge clk);
        if1.i_valid = 1'b0;
        if0.i_valid = 1'b0;
        wait_idle();

        // Reset in the middle of converting 4321.
        send(14'd4321, 16'h4321, 16'h4321, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd1", 32'(if1.o_bcd_data), 32'h0000FFF0);
        chk("midrst_bcd0", 32'(if0.o_bcd_data), 32'h00000000);
        chk("midrst_ready", 32'(if1.o_ready), 32'd1);
        chk("midrst_done", 32'(if1.o_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_commit", 32'(if1.o_bcd_data), 32'h0000FFF0);
        send(14'd4321, 16'h4321, 16'h4321, 1'b0, 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue1_empty", 32'(q1.size()), 32'd0);
        chk("queue0_empty", 32'(q0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
